dis_issue_arbiter: RTL and testbench

- Shares the write ports of one unified issue queue between several dispatch queues, for example the load and store dispatch queues feeding a shared memory issue queue.
- Each requester offers up to REQ_WIDTH head entries per cycle. The block grants an in-order prefix of each requester's offer, within the per-cycle slot limit and the downstream credit count.
- Priority is round-robin between requesters, with a starvation override.
- The block tracks free issue-queue entries with a credit counter and suppresses all grants in a redirect cycle.

---
 rtl/dis_issue_arbiter.sv | 126 ++++++++++++
 tb/tb_dis_issue_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dis_issue_arbiter.sv
// dis_issue_arbiter: shares issue-queue write slots between dispatch queues under round-robin priority,
// a starvation override and credit-based flow control.
module dis_issue_arbiter #(
  parameter int REQ_NUM      = 2,
  parameter int REQ_WIDTH    = 2,
  parameter int OUT_WIDTH    = 2,
  parameter int CREDIT       = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = $clog2(CREDIT+1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [REQ_NUM*REQ_WIDTH-1:0]           req_valid,
  output logic [REQ_NUM*REQ_WIDTH-1:0]           grant,
  output logic [OUT_WIDTH-1:0]                   out_en,
  output logic [OUT_WIDTH*$clog2(REQ_NUM)-1:0]   out_src,
  output logic [OUT_WIDTH*$clog2(REQ_WIDTH)-1:0] out_idx,
  input  logic [CW-1:0]                          release_num,
  input  logic                                   redirect,
  output logic [CW-1:0]                          credit,
  output logic                                   full,
  output logic                                   overflow
);
  localparam int SW  = $clog2(REQ_NUM);
  localparam int KW  = $clog2(REQ_WIDTH);
  localparam int STW = $clog2(STARVE_LIMIT+1);

  logic [CW-1:0]  r_credit;
  logic [SW-1:0]  r_rr;
  logic [STW-1:0] r_starve [REQ_NUM];
  logic           r_overflow;

  int w_len  [REQ_NUM];
  int w_gcnt [REQ_NUM];
  int w_order [REQ_NUM];
  int w_starved, w_total, w_rr_next, w_sum;

  always_comb begin : alloc
    int n, rem, used, r;
    logic hit;
    grant = '0;
    out_en = '0;
    out_src = '0;
    out_idx = '0;
    w_starved = -1;
    w_total = 0;
    n = 0;
    used = 0;
    r = 0;
    hit = 1'b0;
    rem = (int'(r_credit) < OUT_WIDTH) ? int'(r_credit) : OUT_WIDTH;
    for (int q = 0; q < REQ_NUM; q++) begin
      w_len[q] = 0;
      w_gcnt[q] = 0;
      w_order[q] = 0;
      for (int k = 0; k < REQ_WIDTH; k++)
        if (req_valid[q*REQ_WIDTH+k] && w_len[q] == k) w_len[q] = k + 1;
      if (w_starved < 0 && int'(r_starve[q]) >= STARVE_LIMIT) w_starved = q;
    end
    if (w_starved >= 0) begin
      w_order[0] = w_starved;
      n = 1;
    end
    for (int i = 0; i < REQ_NUM; i++) begin
      r = (int'(r_rr) + i) % REQ_NUM;
      if (r != w_starved) begin
        w_order[n] = r;
        n = n + 1;
      end
    end
    // slots are packed in grant order so downstream writes stay contiguous
    for (int j = 0; j < REQ_NUM; j++) begin
      r = w_order[j];
      w_gcnt[r] = (w_len[r] < rem) ? w_len[r] : rem;
      rem = rem - w_gcnt[r];
      w_total = w_total + w_gcnt[r];
      for (int k = 0; k < REQ_WIDTH; k++)
        if (k < w_gcnt[r]) begin
          grant[r*REQ_WIDTH+k] = 1'b1;
          out_en[used] = 1'b1;
          out_src[used*SW +: SW] = SW'(r);
          out_idx[used*KW +: KW] = KW'(k);
          used = used + 1;
        end
    end
    w_rr_next = int'(r_rr);
    for (int i = 0; i < REQ_NUM; i++) begin
      r = (int'(r_rr) + i) % REQ_NUM;
      if (!hit && r != w_starved && w_gcnt[r] > 0) begin
        w_rr_next = (r + 1) % REQ_NUM;
        hit = 1'b1;
      end
    end
    w_sum = int'(r_credit) - (redirect ? 0 : w_total) + int'(release_num);
    if (rst || redirect) begin
      grant = '0;
      out_en = '0;
      out_src = '0;
      out_idx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= CW'(CREDIT);
      r_rr <= '0;
      r_overflow <= 1'b0;
      for (int q = 0; q < REQ_NUM; q++) r_starve[q] <= '0;
    end else begin
      if (w_sum > CREDIT) begin
        r_credit <= CW'(CREDIT);
        r_overflow <= 1'b1;
      end else r_credit <= CW'(w_sum);
      if (!redirect) begin
        r_rr <= SW'(w_rr_next);
        for (int q = 0; q < REQ_NUM; q++)
          if (w_gcnt[q] > 0 || w_len[q] == 0) r_starve[q] <= '0;
          else if (int'(r_starve[q]) < STARVE_LIMIT) r_starve[q] <= r_starve[q] + 1'b1;
      end
    end
  end

  assign credit = r_credit;
  assign full = (r_credit == '0);
  assign overflow = r_overflow;
endmodule

// File: tb/tb_dis_issue_arbiter.sv
// tb_dis_issue_arbiter: randomized scoreboard bench; a queue-based reference model predicts each cycle's
// grants, slots and credit, and a negedge monitor compares the DUT against the queued predictions.
module tb_dis_issue_arbiter;
  localparam int NR = 2, RW = 2, OW = 2, CR = 16, SL = 4, CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req_valid = 4'hF;
  logic [3:0]    grant;
  logic [1:0]    out_en, out_src, out_idx;
  logic [CW-1:0] release_num = '0;
  logic          redirect = 1'b0;
  logic [CW-1:0] credit;
  logic          full, overflow;

  dis_issue_arbiter #(.REQ_NUM(NR), .REQ_WIDTH(RW), .OUT_WIDTH(OW), .CREDIT(CR), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .grant(grant), .out_en(out_en), .out_src(out_src),
    .out_idx(out_idx), .release_num(release_num), .redirect(redirect), .credit(credit), .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] en, src, idx;
    int         credit;
    logic       full, ovf;
  } exp_t;

  exp_t q_exp[$];
  int checks = 0, failures = 0;
  int m_credit = CR, m_rr = 0, m_ovf = 0;
  int m_starve[NR] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // drives one cycle of stimulus, queues the predicted response, then advances the model
  task automatic step(input bit rs, input logic [3:0] req, input int rel, input bit redir);
    exp_t e;
    int len[NR], gcnt[NR], ord[$];
    int st, budget, slot, total, nxt;
    @(posedge clk);
    #1;
    rst = rs;
    req_valid = req;
    release_num = CW'(rel);
    redirect = redir;
    e.grant = '0; e.en = '0; e.src = '0; e.idx = '0;
    e.credit = m_credit;
    e.full = (m_credit == 0);
    e.ovf = (m_ovf != 0);
    st = -1;
    for (int r = 0; r < NR; r++) begin
      len[r] = 0;
      while (len[r] < RW && req[r*RW+len[r]]) len[r]++;
      if (st < 0 && m_starve[r] >= SL) st = r;
    end
    if (st >= 0) ord.push_back(st);
    for (int i = 0; i < NR; i++) if ((m_rr + i) % NR != st) ord.push_back((m_rr + i) % NR);
    budget = (m_credit < OW) ? m_credit : OW;
    slot = 0;
    total = 0;
    foreach (ord[j]) begin
      gcnt[ord[j]] = (len[ord[j]] < budget) ? len[ord[j]] : budget;
      budget -= gcnt[ord[j]];
      total += gcnt[ord[j]];
      for (int k = 0; k < gcnt[ord[j]]; k++) begin
        if (!rs && !redir) begin
          e.grant[ord[j]*RW+k] = 1'b1;
          e.en[slot] = 1'b1;
          e.src[slot] = 1'(ord[j]);
          e.idx[slot] = 1'(k);
        end
        slot++;
      end
    end
    q_exp.push_back(e);
    if (rs) begin
      m_credit = CR; m_rr = 0; m_ovf = 0; m_starve = '{0, 0};
    end else begin
      nxt = m_credit - (redir ? 0 : total) + rel;
      if (nxt > CR) begin m_credit = CR; m_ovf = 1; end else m_credit = nxt;
      if (!redir) begin
        for (int i = NR - 1; i >= 0; i--)
          if ((m_rr + i) % NR != st && gcnt[(m_rr + i) % NR] > 0) nxt = ((m_rr + i) % NR + 1) % NR;
          else if (i == NR - 1) nxt = m_rr;
        m_rr = nxt;
        for (int r = 0; r < NR; r++)
          m_starve[r] = (gcnt[r] > 0 || len[r] == 0) ? 0 : ((m_starve[r] < SL) ? m_starve[r] + 1 : SL);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        exp_t e;
        e = q_exp.pop_front();
        chk("grant", 32'(grant), 32'(e.grant));
        chk("out_en", 32'(out_en), 32'(e.en));
        chk("out_src", 32'(out_src), 32'(e.src));
        chk("out_idx", 32'(out_idx), 32'(e.idx));
        chk("credit", 32'(credit), e.credit);
        chk("full", 32'(full), 32'(e.full));
        chk("overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, mx;
    logic [3:0] req;
    step(1, 4'hF, 0, 0);
    step(1, 4'hF, 0, 0);
    repeat (4) step(0, 4'hF, 0, 0);
    while (m_credit > 1) step(0, (m_credit >= 2) ? 4'hF : 4'h1, 0, 0);
    step(0, 4'hF, 0, 0);
    step(0, 4'hF, 3, 0);
    while (m_credit > 0) step(0, 4'hF, 0, 0);
    repeat (4) step(0, 4'b0100, 0, 0);
    step(0, 4'b0101, 1, 0);
    step(0, 4'b0101, 0, 0);
    step(0, 4'b0101, 1, 0);
    step(0, 4'b0101, 0, 0);
    step(0, 4'h0, 10 - m_credit, 0);
    step(0, 4'hF, 5, 1);
    step(0, 4'hF, 0, 0);
    for (int n = 0; n < 400; n++) begin
      req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req = 4'hF;
      mx = (CR - m_credit < 3) ? CR - m_credit : 3;
      rel = $urandom_range(0, mx);
      step(0, req, rel, $urandom_range(0, 9) == 0);
    end
    step(0, 4'h0, CR - m_credit, 0);
    step(0, 4'h0, 1, 0);
    step(0, 4'h0, 0, 0);
    step(0, 4'h3, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q_exp.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
